rep_seq_checker: RTL

//  Synthesizable run-time checker for  $rose(trig) |=> ##DLY (b <rep>[MIN:MAX]) ##1 c.

---
 rtl/rep_seq_checker.sv | 134 +++++++++++++
 1 files changed

// File: rtl/rep_seq_checker.sv
// rep_seq_checker: run-time checker for $rose(trig) |=> ##DLY (b <rep>[MIN_REP:MAX_REP]) ##1 c
// Optional feature macro: REP_CHK_TIMEOUT_EN (window-cycle timeout, fail_code 3).
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   mode[1:0]             00 [*], 01 [->], 10 [=], 11 [*]; latched at the trig rise
//   trig, b, c            antecedent, repeated and terminating signals
//   busy                  attempt in progress (DELAY or WINDOW)
//   pass, fail            one-cycle result pulses
//   fail_code[1:0]        1 run broken, 2 over-count / missed c, 3 timeout; held until next fail
//   overlap               one-cycle pulse for a trig rise ignored while busy
//   pass_cnt, fail_cnt    saturating tallies
module rep_seq_checker #(
  parameter int MIN_REP = 2,
  parameter int MAX_REP = 4,
  parameter int DLY     = 1,
  parameter int CNT_W   = 16,
  parameter int TIMEOUT = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [1:0]       mode,
  input  logic             trig,
  input  logic             b,
  input  logic             c,
  output logic             busy,
  output logic             pass,
  output logic             fail,
  output logic [1:0]       fail_code,
  output logic             overlap,
  output logic [CNT_W-1:0] pass_cnt,
  output logic [CNT_W-1:0] fail_cnt
);
  typedef enum logic [1:0] {IDLE, DELAY, WINDOW} state_t;
  localparam int KW = $clog2(MAX_REP + 2);
  localparam int DW = (DLY < 2) ? 1 : $clog2(DLY);
  localparam logic [KW-1:0] KMIN = KW'(MIN_REP);
  localparam logic [KW-1:0] KMAX = KW'(MAX_REP);
  state_t state, state_nxt;
  logic trig_q, lb, rise, in_rng, dec_pass, dec_fail, dec, start;
  logic [1:0] mode_q, dec_code;
  logic [DW-1:0] dcnt;
  logic [KW-1:0] k, k_nxt;
`ifdef REP_CHK_TIMEOUT_EN
  localparam int WW = $clog2(TIMEOUT + 1);
  logic [WW-1:0] wcnt;
`endif
  assign rise   = trig & ~trig_q;
  assign in_rng = (k >= KMIN) && (k <= KMAX);
  assign busy   = state != IDLE;
  always_comb begin
    dec_pass = 1'b0;
    dec_fail = 1'b0;
    dec_code = 2'd0;
    k_nxt    = k;
    if (state == WINDOW) begin
      if (mode_q == 2'b01) begin
        if (lb && in_rng && c) dec_pass = 1'b1;
        else if (lb && k == KMAX) begin
          dec_fail = 1'b1;
          dec_code = 2'd2;
        end else k_nxt = k + KW'(b);
      end else if (mode_q == 2'b10) begin
        if (in_rng && c) dec_pass = 1'b1;
        else if (b && k == KMAX) begin
          dec_fail = 1'b1;
          dec_code = 2'd2;
        end else if (b) k_nxt = k + 1'b1;
      end else begin
        if (in_rng && c) dec_pass = 1'b1;
        else if (b && k < KMAX) k_nxt = k + 1'b1;
        else begin
          dec_fail = 1'b1;
          dec_code = 2'd1;
        end
      end
`ifdef REP_CHK_TIMEOUT_EN
      // pass/fail rules win; timeout only fires on an otherwise undecided edge
      if (!dec_pass && !dec_fail && wcnt == WW'(TIMEOUT - 1)) begin
        dec_fail = 1'b1;
        dec_code = 2'd3;
      end
`endif
    end
    dec   = dec_pass | dec_fail;
    // a rise on the decision edge is a fresh attempt, not an overlap
    start = rise && (state == IDLE || dec);
    state_nxt = start ? ((DLY == 0) ? WINDOW : DELAY)
              : dec ? IDLE
              : (state == DELAY && dcnt == DW'(DLY - 1)) ? WINDOW
              : state;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      trig_q    <= 1'b0;
      mode_q    <= 2'd0;
      dcnt      <= '0;
      k         <= '0;
      lb        <= 1'b0;
      pass      <= 1'b0;
      fail      <= 1'b0;
      fail_code <= 2'd0;
      overlap   <= 1'b0;
      pass_cnt  <= '0;
      fail_cnt  <= '0;
`ifdef REP_CHK_TIMEOUT_EN
      wcnt      <= '0;
`endif
    end else begin
      state   <= state_nxt;
      trig_q  <= trig;
      pass    <= dec_pass;
      fail    <= dec_fail;
      overlap <= rise && !start;
      if (dec_fail) fail_code <= dec_code;
      if (dec_pass && pass_cnt != '1) pass_cnt <= pass_cnt + 1'b1;
      if (dec_fail && fail_cnt != '1) fail_cnt <= fail_cnt + 1'b1;
      if (start) begin
        mode_q <= mode;
        dcnt   <= '0;
        k      <= '0;
        lb     <= 1'b0;
      end else if (state == DELAY) dcnt <= dcnt + 1'b1;
      else if (state == WINDOW) begin
        k  <= k_nxt;
        lb <= b;
      end
`ifdef REP_CHK_TIMEOUT_EN
      if (start) wcnt <= '0;
      else if (state == WINDOW) wcnt <= wcnt + 1'b1;
`endif
    end
  end
endmodule
